// File: rtl/scan_index_gen_pkg.sv
// Shared types and constants for the scan index generator.
package scan_index_gen_pkg;

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] IDX_ZERO = 3'd0;

  localparam logic MODE_CONT   = 1'b0;
  localparam logic MODE_SINGLE = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    DWELL   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/scan_index_gen_next_idx.sv
// Combinational search for the first and the next unmasked scan index.
// An all-zero mask yields a plain in-order sequence 0..LAST_IDX.
module scan_next_idx
  import scan_index_gen_pkg::*;
#(
  parameter int LAST_IDX = 7
) (
  input  logic [IDX_W-1:0] cur_idx,
  input  logic [7:0]       mask,
  output logic [IDX_W-1:0] first_idx,
  output logic [IDX_W-1:0] next_idx,
  output logic             wrap,
  output logic             none_valid
);

  logic [IDX_W-1:0] cand_s;
  logic             found_s;
  logic             hit_s;

  // Walk downward so the lowest qualifying index is the one left standing
  always_comb begin
    first_idx  = IDX_ZERO;
    cand_s     = IDX_ZERO;
    found_s    = 1'b0;
    hit_s      = 1'b0;
    none_valid = 1'b1;
    for (int i = LAST_IDX; i >= 0; i--) begin
      hit_s      = !mask[i] && (i > int'(cur_idx));
      first_idx  = mask[i] ? first_idx : IDX_W'(i);
      cand_s     = hit_s ? IDX_W'(i) : cand_s;
      found_s    = found_s | hit_s;
      none_valid = none_valid & mask[i];
    end
    wrap     = !found_s;
    next_idx = found_s ? cand_s : first_idx;
  end

endmodule

// File: rtl/scan_index_gen.sv
// Index scanner driving a 3-to-8 decoder select through a valid/ready handshake.
// Optional SCAN_SKIP_MASK_EN adds skip_mask to suppress selected indices.
module scan_index_gen
  import scan_index_gen_pkg::*;
#(
  parameter int DWELL_W  = 16,
  parameter int LAST_IDX = 7
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [IDX_W-1:0]   idx_o,
  output logic               idx_valid,
  input  logic               idx_ready,
`ifdef SCAN_SKIP_MASK_EN
  input  logic [7:0]         skip_mask,
`endif
  output logic               busy,
  output logic               sweep_done
);

  localparam logic [DWELL_W-1:0] CNT_ZERO = {DWELL_W{1'b0}};
  localparam logic [DWELL_W-1:0] CNT_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

  scan_state_e        state_r, state_nxt_s;
  logic [IDX_W-1:0]   idx_r, idx_nxt_s;
  logic [DWELL_W-1:0] cnt_r, cnt_nxt_s;
  logic [DWELL_W-1:0] dwell_r, dwell_nxt_s;
  logic               mode_r, mode_nxt_s;
  logic               valid_r, busy_r, done_r, done_nxt_s;
  logic [7:0]         mask_s;
  logic [IDX_W-1:0]   first_idx_s, next_idx_s;
  logic               wrap_s, none_valid_s, handshake_s, launch_s;

`ifdef SCAN_SKIP_MASK_EN
  assign mask_s = skip_mask;
`else
  assign mask_s = 8'h00;
`endif

  scan_next_idx #(.LAST_IDX(LAST_IDX)) u_next (
    .cur_idx   (idx_r),
    .mask      (mask_s),
    .first_idx (first_idx_s),
    .next_idx  (next_idx_s),
    .wrap      (wrap_s),
    .none_valid(none_valid_s)
  );

  assign handshake_s = valid_r && idx_ready;
  assign launch_s    = start && !stop && !none_valid_s;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; stop overrides every other request
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (launch_s) state_nxt_s = PRESENT;
        else          state_nxt_s = IDLE;
      end
      PRESENT: begin
        if (stop)             state_nxt_s = IDLE;
        else if (handshake_s) state_nxt_s = DWELL;
        else                  state_nxt_s = PRESENT;
      end
      DWELL: begin
        if (stop)                                  state_nxt_s = IDLE;
        else if (cnt_r != CNT_ZERO)                state_nxt_s = DWELL;
        else if (wrap_s && mode_r == MODE_SINGLE)  state_nxt_s = IDLE;
        else                                       state_nxt_s = PRESENT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath next values: index, dwell counter, latched configuration, sweep pulse
  always_comb begin
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    mode_nxt_s  = mode_r;
    dwell_nxt_s = dwell_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (launch_s) begin
          idx_nxt_s   = first_idx_s;
          mode_nxt_s  = mode;
          dwell_nxt_s = dwell;
        end else begin
          idx_nxt_s = IDX_ZERO;
        end
      end
      PRESENT: begin
        if (stop) begin
          idx_nxt_s = IDX_ZERO;
          cnt_nxt_s = CNT_ZERO;
        end else if (handshake_s) begin
          cnt_nxt_s = dwell_r;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      DWELL: begin
        if (stop) begin
          idx_nxt_s = IDX_ZERO;
          cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == CNT_ZERO) begin
          done_nxt_s = wrap_s;
          idx_nxt_s  = (wrap_s && mode_r == MODE_SINGLE) ? IDX_ZERO : next_idx_s;
        end else begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        idx_nxt_s = IDX_ZERO;
        cnt_nxt_s = CNT_ZERO;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= IDX_ZERO;
      cnt_r   <= CNT_ZERO;
      mode_r  <= MODE_CONT;
      dwell_r <= CNT_ZERO;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
      mode_r  <= mode_nxt_s;
      dwell_r <= dwell_nxt_s;
      valid_r <= (state_nxt_s == PRESENT);
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= done_nxt_s;
    end
  end

  assign idx_o      = idx_r;
  assign idx_valid  = valid_r;
  assign busy       = busy_r;
  assign sweep_done = done_r;

endmodule

// File: tb/tb_scan_index_gen.sv
// Scoreboard bench for scan_index_gen: stimulus queues expected handshakes,
// a negedge monitor pops and compares index and spacing.
module tb_scan_index_gen;

  localparam int DWELL_W = 16;

  logic               clk = 1'b0;
  logic               rst_n, start, stop, mode, idx_ready;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         idx_o;
  logic               idx_valid, busy, sweep_done;
`ifdef SCAN_SKIP_MASK_EN
  logic [7:0]         skip_mask;
`endif

  typedef struct {
    logic [2:0] idx;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   sd_cyc_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0, hs_cnt = 0, sd_cnt = 0, last_hs = 0;
  int   hs_base, sd_base;

  scan_index_gen #(.DWELL_W(DWELL_W), .LAST_IDX(7)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .dwell     (dwell),
    .idx_o     (idx_o),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
`ifdef SCAN_SKIP_MASK_EN
    .skip_mask (skip_mask),
`endif
    .busy      (busy),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: compare each accepted index against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (sweep_done) begin
        sd_cnt++;
        sd_cyc_q.push_back(cyc);
      end
      if (idx_valid && idx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_hs: got idx %0d expected no handshake (t=%0t)", idx_o, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("hs_idx", int'(idx_o), int'(mon_e.idx));
          if (mon_e.gap > 0) chk("hs_gap", cyc - last_hs, mon_e.gap);
        end
        last_hs = cyc;
        hs_cnt++;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      done = !busy;
    end
    chk(name, int'(done), 1);
  endtask

  task automatic wait_hs(input string name, input int target, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      done = (hs_cnt >= target);
    end
    chk(name, int'(done), 1);
  endtask

  task automatic push_exp(input int idx, input int gap);
    exp_t e;
    e.idx = 3'(idx);
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    idx_ready = 1'b0; dwell = 16'd0;
`ifdef SCAN_SKIP_MASK_EN
    skip_mask = 8'h00;
`endif
    #12;
    chk("rst_idx", int'(idx_o), 0);
    chk("rst_valid", int'(idx_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(sweep_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single sweep, dwell 2: one PRESENT + three DWELL cycles per index
    mode = 1'b1; dwell = 16'd2; idx_ready = 1'b1;
    sd_base = sd_cnt;
    for (int k = 0; k < 8; k++) push_exp(k, (k == 0) ? 0 : 4);
    pulse_start();
    wait_idle("single_idle_timeout", 100);
    @(posedge clk); #1;
    chk("single_sd_count", sd_cnt - sd_base, 1);
    chk("single_sd_low", int'(sweep_done), 0);
    chk("single_idx0", int'(idx_o), 0);
    chk("single_busy", int'(busy), 0);
    chk("single_q_empty", exp_q.size(), 0);

    // Continuous, dwell 0: index every 2 cycles, sweep_done every 16
    mode = 1'b0; dwell = 16'd0;
    sd_cyc_q.delete();
    hs_base = hs_cnt;
    for (int k = 0; k < 20; k++) push_exp(k % 8, (k == 0) ? 0 : 2);
    pulse_start();
    wait_hs("cont_hs_timeout", hs_base + 20, 100);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("cont_stop_busy", int'(busy), 0);
    chk("cont_stop_idx", int'(idx_o), 0);
    chk("cont_stop_valid", int'(idx_valid), 0);
    chk("cont_sd_count", sd_cyc_q.size(), 2);
    chk("cont_sd_period", (sd_cyc_q.size() >= 2) ? sd_cyc_q[1] - sd_cyc_q[0] : -1, 16);

    // Stall in PRESENT; mode/dwell changes after start must not matter
    mode = 1'b1; dwell = 16'd1; idx_ready = 1'b0;
    sd_base = sd_cnt;
    for (int k = 0; k < 8; k++) push_exp(k, (k == 0) ? 0 : 3);
    pulse_start();
    mode = 1'b0; dwell = 16'd9;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", int'(idx_valid), 1);
      chk("stall_idx", int'(idx_o), 0);
    end
    @(posedge clk); #1;
    idx_ready = 1'b1;
    wait_idle("stall_idle_timeout", 100);
    @(posedge clk); #1;
    chk("stall_sd_count", sd_cnt - sd_base, 1);
    chk("stall_q_empty", exp_q.size(), 0);

    // Stop mid-DWELL at index 4
    mode = 1'b0; dwell = 16'd3;
    sd_base = sd_cnt;
    hs_base = hs_cnt;
    for (int k = 0; k < 5; k++) push_exp(k, (k == 0) ? 0 : 5);
    pulse_start();
    wait_hs("stop_hs_timeout", hs_base + 5, 100);
    chk("stop_in_dwell", int'(idx_valid), 0);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_idx", int'(idx_o), 0);
    chk("stop_valid", int'(idx_valid), 0);
    repeat (10) @(posedge clk);
    #1;
    chk("stop_no_sd", sd_cnt - sd_base, 0);
    chk("stop_still_idle", int'(busy), 0);

    // Asynchronous reset mid-DWELL at index 5, then start on first edge after release
    hs_base = hs_cnt;
    for (int k = 0; k < 6; k++) push_exp(k, (k == 0) ? 0 : 5);
    pulse_start();
    wait_hs("rst_hs_timeout", hs_base + 6, 100);
    rst_n = 1'b0;
    #1;
    chk("arst_idx", int'(idx_o), 0);
    chk("arst_valid", int'(idx_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(sweep_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1; start = 1'b1; idx_ready = 1'b0; mode = 1'b1; dwell = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rel_start_valid", int'(idx_valid), 1);
    chk("rel_start_busy", int'(busy), 1);
    chk("rel_start_idx", int'(idx_o), 0);
    pulse_stop();
    chk("rel_stop_busy", int'(busy), 0);
    chk("rst_no_sd", sd_cnt - sd_base, 0);

    // Start and stop together: stop wins
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", int'(busy), 0);
    chk("ss_valid", int'(idx_valid), 0);

`ifdef SCAN_SKIP_MASK_EN
    // Masked indices are skipped; fully masked start is ignored
    idx_ready = 1'b1; mode = 1'b1; dwell = 16'd0;
    skip_mask = 8'b1010_0101;
    sd_base = sd_cnt;
    push_exp(1, 0); push_exp(3, 2); push_exp(4, 2); push_exp(6, 2);
    pulse_start();
    wait_idle("mask_idle_timeout", 100);
    @(posedge clk); #1;
    chk("mask_sd_count", sd_cnt - sd_base, 1);
    chk("mask_q_empty", exp_q.size(), 0);
    skip_mask = 8'hFF;
    pulse_start();
    chk("mask_all_busy", int'(busy), 0);
    chk("mask_all_valid", int'(idx_valid), 0);
    skip_mask = 8'h00;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
